// File: rtl/mmc_cmd_if.sv
// Command/response bus between the MMC command sequencer, its host-side
// controller, the clock-control tick/done handshake and the CMD pad.
interface mmc_cmd_if;
  logic         cmd_start;
  logic         cmd_abort;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         crc_chk;
  logic         cmd_busy;
  logic         cmd_done;
  logic         resp_timeout;
  logic         resp_crc_err;
  logic [127:0] resp_data;
  logic         clk_tick;
  logic         clk_done;
  logic         mmc_cmd_o;
  logic         mmc_cmd_oe;
  logic         mmc_cmd_i;

  modport master (
    output cmd_start, cmd_abort, cmd_index, cmd_arg, resp_type, crc_chk,
    input  cmd_busy, cmd_done, resp_timeout, resp_crc_err, resp_data,
    input  clk_tick, output clk_done,
    input  mmc_cmd_o, mmc_cmd_oe, output mmc_cmd_i
  );

  modport slave (
    input  cmd_start, cmd_abort, cmd_index, cmd_arg, resp_type, crc_chk,
    output cmd_busy, cmd_done, resp_timeout, resp_crc_err, resp_data,
    output clk_tick, input clk_done,
    output mmc_cmd_o, mmc_cmd_oe, input mmc_cmd_i
  );
endinterface

// File: rtl/mmc_cmd_sequencer.sv
// Runs one MMC command transaction on CMD: frame TX with CRC7, response wait,
// response capture/CRC check and the Ncc gap, paced by the clock-control tick/done.
//
// state   | meaning
// IDLE    | waiting for cmd_start
// TX      | shifting out the 48-bit command frame
// WAIT    | CMD released, looking for the response start bit (Ncr window)
// RX      | shifting in the remaining response bits
// NCC     | recovery clocks with CMD released
// ABORT   | CMD released, draining the outstanding clk_done
module mmc_cmd_sequencer #(
  parameter int NCR_TIMEOUT = 64,
  parameter int NCC_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic     wb_clk_i,
  input  logic     wb_rst_i,
  mmc_cmd_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_NCC,
    S_ABORT
  } state_t;

  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(47);
  localparam logic [CNT_W-1:0] NCR_LOAD  = CNT_W'(NCR_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] NCR_ARMED = CNT_W'(NCR_TIMEOUT - 2);
  localparam logic [CNT_W-1:0] NCC_LOAD  = CNT_W'(NCC_CYCLES - 1);
  localparam logic [CNT_W-1:0] RX_SHORT  = CNT_W'(46);
  localparam logic [CNT_W-1:0] RX_LONG   = CNT_W'(134);

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_q, wait_d;
  logic             done_q, done_d;
  logic [47:0]      tx_q;
  logic [127:0]     resp_q;
  logic             want_resp_q, long_q, chk_q;
  logic             to_q, crc_err_q;

  logic             tick, paced, bit_ev;
  logic             ld_frame, tx_shift, rx_clear, rx_shift, set_to, set_crc;
  logic [39:0]      tx_body;
  logic [6:0]       tx_crc, rx_crc;

  assign tx_body = {2'b01, bus.cmd_index, bus.cmd_arg};
  assign tx_crc  = crc7(tx_body);
  // On the last RX bit the frame is {resp_q[46:0], cmd_i}: body in [46:7], CRC in [6:0].
  assign rx_crc  = crc7(resp_q[46:7]);
  assign paced   = (state_q == S_TX) || (state_q == S_WAIT) ||
                   (state_q == S_RX) || (state_q == S_NCC);
  assign bit_ev  = wait_q & bus.clk_done;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wait_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    done_d   = 1'b0;
    tick     = 1'b0;
    ld_frame = 1'b0;
    tx_shift = 1'b0;
    rx_clear = 1'b0;
    rx_shift = 1'b0;
    set_to   = 1'b0;
    set_crc  = 1'b0;

    if (paced && !wait_q) begin
      tick   = 1'b1;
      wait_d = 1'b1;
    end else if (bit_ev) begin
      wait_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        wait_d = 1'b0;
        if (bus.cmd_start) begin
          ld_frame = 1'b1;
          state_d  = S_TX;
          cnt_d    = TX_LAST;
        end
      end
      S_TX: if (bit_ev) begin
        tx_shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = want_resp_q ? S_WAIT : S_NCC;
          cnt_d   = want_resp_q ? NCR_LOAD : NCC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WAIT: if (bit_ev) begin
        // The first two clocks are the Z-Z turnaround: counted, never a start bit.
        if (cnt_q < NCR_ARMED && !bus.mmc_cmd_i) begin
          rx_clear = 1'b1;
          state_d  = S_RX;
          cnt_d    = long_q ? RX_LONG : RX_SHORT;
        end else if (cnt_q == '0) begin
          set_to  = 1'b1;
          state_d = S_NCC;
          cnt_d   = NCC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RX: if (bit_ev) begin
        rx_shift = 1'b1;
        if (cnt_q == '0) begin
          set_crc = !long_q && chk_q && (rx_crc != resp_q[6:0]);
          state_d = S_NCC;
          cnt_d   = NCC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_NCC: if (bit_ev) begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ABORT: if (bus.clk_done) begin
        state_d = S_NCC;
        cnt_d   = NCC_LOAD;
        wait_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // A tick issued this very cycle still owes us a clk_done, so drain it first.
    if (bus.cmd_abort && (state_q == S_TX || state_q == S_WAIT || state_q == S_RX)) begin
      tx_shift = 1'b0;
      rx_clear = 1'b0;
      rx_shift = 1'b0;
      set_to   = 1'b0;
      set_crc  = 1'b0;
      if (tick || (wait_q && !bus.clk_done)) begin
        state_d = S_ABORT;
        wait_d  = 1'b1;
      end else begin
        state_d = S_NCC;
        cnt_d   = NCC_LOAD;
        wait_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_q        <= {48{1'b1}};
      resp_q      <= '0;
      want_resp_q <= 1'b0;
      long_q      <= 1'b0;
      chk_q       <= 1'b0;
      to_q        <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      if (ld_frame) begin
        tx_q        <= {tx_body, tx_crc, 1'b1};
        want_resp_q <= (bus.resp_type == 2'd1) || (bus.resp_type == 2'd2);
        long_q      <= (bus.resp_type == 2'd2);
        chk_q       <= bus.crc_chk;
        to_q        <= 1'b0;
        crc_err_q   <= 1'b0;
      end else if (tx_shift) begin
        tx_q <= {tx_q[46:0], 1'b1};
      end
      if (rx_clear) resp_q <= '0;
      else if (rx_shift) resp_q <= {resp_q[126:0], bus.mmc_cmd_i};
      if (set_to) to_q <= 1'b1;
      if (set_crc) crc_err_q <= 1'b1;
    end
  end

  assign bus.cmd_busy     = (state_q != S_IDLE);
  assign bus.cmd_done     = done_q;
  assign bus.resp_timeout = to_q;
  assign bus.resp_crc_err = crc_err_q;
  assign bus.resp_data    = resp_q;
  assign bus.clk_tick     = tick;
  assign bus.mmc_cmd_oe   = (state_q == S_TX);
  assign bus.mmc_cmd_o    = (state_q == S_TX) ? tx_q[47] : 1'b1;

endmodule

// File: tb/tb_mmc_cmd_sequencer.sv
// Directed bench for mmc_cmd_sequencer with a clock-control and MMC card model.
module tb_mmc_cmd_sequencer;
  logic wb_clk_i = 1'b0;
  logic wb_rst_i;

  mmc_cmd_if bus ();

  mmc_cmd_sequencer dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .bus     (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // clock-control / card model state
  int           tick_cnt = 0, oe_ticks = 0, z_ticks = 0, tick_err = 0, done_cnt = 0;
  int           tx_cnt = 0, post_tx = 0, ridx = 0, resp_len = 0, z_clocks = 0, delay = 0;
  logic [47:0]  tx_cap = '0;
  logic [135:0] resp_frame = '0;
  logic         cur_oe = 1'b0, cur_o = 1'b1;

  initial begin
    bus.clk_done  = 1'b0;
    bus.mmc_cmd_i = 1'b1;
    forever begin
      @(negedge wb_clk_i);
      if (bus.clk_done) begin
        bus.clk_done  = 1'b0;
        bus.mmc_cmd_i = 1'b1;
      end
      if (bus.cmd_done) done_cnt++;
      if (bus.clk_tick) begin
        if (delay > 0) tick_err++;
        tick_cnt++;
        cur_oe = bus.mmc_cmd_oe;
        cur_o  = bus.mmc_cmd_o;
        if (cur_oe) oe_ticks++;
        else z_ticks++;
        delay = 2;
      end else if (delay > 0) begin
        delay--;
        if (delay == 0) begin
          bus.clk_done = 1'b1;
          if (cur_oe) begin
            tx_cap = {tx_cap[46:0], cur_o};
            tx_cnt++;
          end else if (tx_cnt >= 48) begin
            post_tx++;
            if (resp_len > 0 && post_tx > z_clocks && ridx < resp_len) begin
              bus.mmc_cmd_i = resp_frame[resp_len-1-ridx];
              ridx++;
            end
          end
        end
      end
    end
  end

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                           input logic cc, input logic [135:0] frame, input int len, input int z);
    @(posedge wb_clk_i); #1;
    tick_cnt = 0; oe_ticks = 0; z_ticks = 0; tick_err = 0; done_cnt = 0;
    tx_cnt = 0; post_tx = 0; ridx = 0; tx_cap = '0;
    resp_frame = frame; resp_len = len; z_clocks = z;
    @(negedge wb_clk_i);
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.resp_type = rt;
    bus.crc_chk   = cc;
    bus.cmd_start = 1'b1;
    @(negedge wb_clk_i);
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge wb_clk_i);
      if (bus.cmd_done) seen = 1'b1;
    end
    check(tag, 128'(seen), 128'd1);
    repeat (3) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wait_tx(input int n);
    int i = 0;
    while (tx_cnt < n && i < 2000) begin @(posedge wb_clk_i); #1; i++; end
    check("wait_tx_bits", 128'(tx_cnt), 128'(n));
    i = 0;
    while (!bus.clk_tick && i < 20) begin @(posedge wb_clk_i); #1; i++; end
  endtask

  localparam logic [135:0] R7_OK  = 136'h08000001AA13;
  localparam logic [135:0] R7_BAD = 136'h08000001AA1B;
  localparam logic [127:0] CID    = 128'h0123456789ABCDEF0123456789ABCDEF;

  int snap;

  initial begin
    wb_rst_i      = 1'b1;
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.resp_type = '0;
    bus.crc_chk   = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_busy", 128'(bus.cmd_busy), 0);
    check("rst_oe", 128'(bus.mmc_cmd_oe), 0);
    check("rst_o", 128'(bus.mmc_cmd_o), 1);
    check("rst_tick", 128'(bus.clk_tick), 0);
    check("rst_resp", bus.resp_data, 0);
    wb_rst_i = 1'b0;

    // CMD0, no response
    start_cmd(6'd0, 32'd0, 2'd0, 1'b0, '0, 0, 0);
    wait_done("cmd0_done");
    check("cmd0_tx", 128'(tx_cap), 128'h400000000095);
    check("cmd0_oe_clks", 128'(oe_ticks), 48);
    check("cmd0_ncc_clks", 128'(z_ticks), 8);
    check("cmd0_done_cnt", 128'(done_cnt), 1);
    check("cmd0_busy", 128'(bus.cmd_busy), 0);
    check("cmd0_tick_err", 128'(tick_err), 0);

    // CMD2, long R2; CRC check requested but must not apply to long responses
    start_cmd(6'd2, 32'd0, 2'd2, 1'b1, {2'b00, 6'b111111, CID}, 136, 5);
    wait_done("cmd2_done");
    check("cmd2_resp", bus.resp_data, CID);
    check("cmd2_crc_err", 128'(bus.resp_crc_err), 0);
    check("cmd2_timeout", 128'(bus.resp_timeout), 0);
    check("cmd2_z_clks", 128'(z_ticks), 6 + 135 + 8);

    // CMD8 with valid R7 after 5 Z clocks; upper response bits must clear
    start_cmd(6'd8, 32'h000001AA, 2'd1, 1'b1, R7_OK, 48, 5);
    wait_done("cmd8_done");
    check("cmd8_tx", 128'(tx_cap), 128'h48000001AA87);
    check("cmd8_resp", bus.resp_data, 128'h08000001AA13);
    check("cmd8_crc_err", 128'(bus.resp_crc_err), 0);
    check("cmd8_timeout", 128'(bus.resp_timeout), 0);
    check("cmd8_z_clks", 128'(z_ticks), 6 + 47 + 8);

    // corrupted CRC, start bit on the first clock after turnaround
    start_cmd(6'd8, 32'h000001AA, 2'd1, 1'b1, R7_BAD, 48, 2);
    wait_done("badcrc_done");
    check("badcrc_err", 128'(bus.resp_crc_err), 1);
    check("badcrc_resp", bus.resp_data, 128'h08000001AA1B);
    check("badcrc_z_clks", 128'(z_ticks), 3 + 47 + 8);

    start_cmd(6'd8, 32'h000001AA, 2'd1, 1'b0, R7_BAD, 48, 2);
    wait_done("nochk_done");
    check("nochk_err", 128'(bus.resp_crc_err), 0);

    // no card: Ncr timeout
    start_cmd(6'd13, 32'd0, 2'd1, 1'b1, '0, 0, 0);
    wait_done("to_done");
    check("to_flag", 128'(bus.resp_timeout), 1);
    check("to_oe_clks", 128'(oe_ticks), 48);
    check("to_z_clks", 128'(z_ticks), 64 + 8);
    check("to_crc_err", 128'(bus.resp_crc_err), 0);

    // start while busy is ignored, then abort at TX bit 20
    start_cmd(6'd17, 32'h00001000, 2'd1, 1'b1, '0, 0, 0);
    wait_tx(5);
    @(negedge wb_clk_i);
    check("abort_busy", 128'(bus.cmd_busy), 1);
    bus.cmd_index = 6'h3F;
    bus.cmd_arg   = 32'hFFFFFFFF;
    bus.resp_type = 2'd0;
    bus.cmd_start = 1'b1;
    @(negedge wb_clk_i);
    bus.cmd_start = 1'b0;
    wait_tx(20);
    @(negedge wb_clk_i);
    bus.cmd_abort = 1'b1;
    @(posedge wb_clk_i); #1;
    check("abort_oe", 128'(bus.mmc_cmd_oe), 0);
    check("abort_o", 128'(bus.mmc_cmd_o), 1);
    check("abort_tick", 128'(bus.clk_tick), 0);
    snap = tick_cnt;
    @(negedge wb_clk_i);
    bus.cmd_abort = 1'b0;
    wait_done("abort_done");
    check("abort_tx_bits", 128'(tx_cnt), 21);
    check("abort_tx_prefix", 128'(tx_cap[20:0]), 128'h0A2000);
    check("abort_ncc_ticks", 128'(tick_cnt - snap), 8);
    check("abort_z_clks", 128'(z_ticks), 8);
    check("abort_tick_err", 128'(tick_err), 0);
    check("abort_done_cnt", 128'(done_cnt), 1);

    // reset at TX bit 20, stray clk_done afterwards
    start_cmd(6'd0, 32'd0, 2'd0, 1'b0, '0, 0, 0);
    wait_tx(20);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("mrst_busy", 128'(bus.cmd_busy), 0);
    check("mrst_oe", 128'(bus.mmc_cmd_oe), 0);
    check("mrst_o", 128'(bus.mmc_cmd_o), 1);
    check("mrst_tick", 128'(bus.clk_tick), 0);
    check("mrst_done", 128'(bus.cmd_done), 0);
    check("mrst_resp", bus.resp_data, 0);
    check("mrst_flags", 128'({bus.resp_timeout, bus.resp_crc_err}), 0);
    snap = tick_cnt;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (10) @(posedge wb_clk_i);
    #1;
    check("stray_busy", 128'(bus.cmd_busy), 0);
    check("stray_ticks", 128'(tick_cnt), 128'(snap));
    check("stray_done", 128'(done_cnt), 0);

    start_cmd(6'd0, 32'd0, 2'd0, 1'b0, '0, 0, 0);
    wait_done("post_rst_done");
    check("post_rst_tx", 128'(tx_cap), 128'h400000000095);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
